// File: rtl/alu_muldiv_pkg.sv
// rtl/alu_muldiv_pkg.sv - opcode encodings and FSM states shared by the ALU and the mul/div unit
package alu_muldiv_pkg;

  localparam logic [5:0] OP_MFHI  = 6'h10;
  localparam logic [5:0] OP_MTHI  = 6'h11;
  localparam logic [5:0] OP_MFLO  = 6'h12;
  localparam logic [5:0] OP_MTLO  = 6'h13;
  localparam logic [5:0] OP_MULT  = 6'h18;
  localparam logic [5:0] OP_MULTU = 6'h19;
  localparam logic [5:0] OP_DIV   = 6'h1a;
  localparam logic [5:0] OP_DIVU  = 6'h1b;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_muldiv_step.sv
// rtl/alu_muldiv_step.sv - one shift-add (multiply) or restoring shift-subtract (divide) iteration
module muldiv_step
  import alu_muldiv_pkg::*;
#(
  parameter int SIZE = 32
) (
  input  logic              mode,
  input  logic [2*SIZE-1:0] acc_in,
  input  logic [SIZE-1:0]   operand,
  output logic [2*SIZE-1:0] acc_out
);

  logic [SIZE:0] sum;
  logic [SIZE:0] rem_sh;
  logic [SIZE:0] diff;

  // Multiply: acc = {partial product, remaining multiplier bits}.
  // Divide:   acc = {partial remainder, dividend bits / quotient bits}.
  always_comb begin
    sum     = {1'b0, acc_in[2*SIZE-1:SIZE]} + {1'b0, operand};
    rem_sh  = acc_in[2*SIZE-1:SIZE-1];
    diff    = rem_sh - {1'b0, operand};
    acc_out = acc_in;
    if (mode == MODE_MUL) begin
      if (acc_in[0]) acc_out = {sum, acc_in[SIZE-1:1]};
      else           acc_out = {1'b0, acc_in[2*SIZE-1:1]};
    end else begin
      if (!diff[SIZE]) acc_out = {diff[SIZE-1:0], acc_in[SIZE-2:0], 1'b1};
      else             acc_out = {rem_sh[SIZE-1:0], acc_in[SIZE-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - iterative signed/unsigned multiply/divide unit with architectural HI/LO
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter int SIZE    = 32,
  parameter int OP_SIZE = 6
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [OP_SIZE-1:0] operation,
  input  logic [SIZE-1:0]    operand1,
  input  logic [SIZE-1:0]    operand0,
  output logic [SIZE-1:0]    result,
  output logic               write_enable,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic [SIZE-1:0]    hi,
  output logic [SIZE-1:0]    lo
);

  localparam int CW = $clog2(SIZE);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*SIZE-1:0] acc_q, acc_d, step_out, prod;
  logic [SIZE-1:0]   opnd_q, opnd_d, raw_q, raw_d;
  logic              mode_q, mode_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d, dz_q, dz_d;
  logic [SIZE-1:0]   hi_q, hi_d, lo_q, lo_d, result_q, result_d;
  logic              we_q, we_d, busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
  logic              is_muldiv, is_signed, is_div, s1, s0;
  logic [SIZE-1:0]   m1, m0, quot, rem;

  muldiv_step #(.SIZE(SIZE)) u_step (
    .mode   (mode_q),
    .acc_in (acc_q),
    .operand(opnd_q),
    .acc_out(step_out)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    raw_d    = raw_q;
    mode_d   = mode_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    busy_d   = busy_q;
    we_d     = 1'b0;
    done_d   = 1'b0;
    dbz_d    = 1'b0;

    is_muldiv = (operation == OP_SIZE'(OP_MULT)) || (operation == OP_SIZE'(OP_MULTU)) ||
                (operation == OP_SIZE'(OP_DIV))  || (operation == OP_SIZE'(OP_DIVU));
    is_signed = (operation == OP_SIZE'(OP_MULT)) || (operation == OP_SIZE'(OP_DIV));
    is_div    = (operation == OP_SIZE'(OP_DIV))  || (operation == OP_SIZE'(OP_DIVU));
    s1 = is_signed & operand1[SIZE-1];
    s0 = is_signed & operand0[SIZE-1];
    m1 = s1 ? -operand1 : operand1;
    m0 = s0 ? -operand0 : operand0;

    // neg_lo carries the product/quotient sign, neg_hi the remainder (dividend) sign
    prod = neg_lo_q ? -acc_q : acc_q;
    quot = neg_lo_q ? -acc_q[SIZE-1:0] : acc_q[SIZE-1:0];
    rem  = neg_hi_q ? -acc_q[2*SIZE-1:SIZE] : acc_q[2*SIZE-1:SIZE];

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_muldiv) begin
            mode_d   = is_div ? MODE_DIV : MODE_MUL;
            acc_d    = {{SIZE{1'b0}}, (is_div ? m1 : m0)};
            opnd_d   = is_div ? m0 : m1;
            raw_d    = operand1;
            neg_lo_d = s1 ^ s0;
            neg_hi_d = s1;
            dz_d     = is_div && (operand0 == '0);
            cnt_d    = CW'(SIZE - 1);
            busy_d   = 1'b1;
            state_d  = ST_RUN;
          end else if (operation == OP_SIZE'(OP_MFHI)) begin
            result_d = hi_q;
            we_d     = 1'b1;
          end else if (operation == OP_SIZE'(OP_MFLO)) begin
            result_d = lo_q;
            we_d     = 1'b1;
          end else if (operation == OP_SIZE'(OP_MTHI)) begin
            hi_d = operand1;
          end else if (operation == OP_SIZE'(OP_MTLO)) begin
            lo_d = operand1;
          end
        end
      end
      ST_RUN: begin
        acc_d = step_out;
        if (cnt_q == '0) state_d = ST_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (mode_q == MODE_MUL) begin
          {hi_d, lo_d} = prod;
        end else if (dz_q) begin
          hi_d  = raw_q;
          lo_d  = '1;
          dbz_d = 1'b1;
        end else begin
          hi_d = rem;
          lo_d = quot;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      raw_q    <= '0;
      mode_q   <= MODE_MUL;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      raw_q    <= raw_d;
      mode_q   <= mode_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      we_q     <= we_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign result       = result_q;
  assign write_enable = we_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign div_by_zero  = dbz_q;
  assign hi           = hi_q;
  assign lo           = lo_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// tb/tb_alu_muldiv.sv - self-checking bench for alu_muldiv against an arithmetic reference model
module tb_alu_muldiv;
  import alu_muldiv_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [5:0]  operation;
  logic [31:0] operand1, operand0;
  logic [31:0] result, hi, lo;
  logic        write_enable, busy, done, div_by_zero;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a, b, ehi, elo;
    logic        edz;
  } vec_t;

  vec_t vecs [8];

  alu_muldiv #(.SIZE(32), .OP_SIZE(6)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .operation   (operation),
    .operand1    (operand1),
    .operand0    (operand0),
    .result      (result),
    .write_enable(write_enable),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero.
  function automatic void model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] ehi, output logic [31:0] elo, output logic edz);
    longint          sa, sb, p;
    longint unsigned up;
    edz = 1'b0;
    ehi = '0;
    elo = '0;
    if (op == OP_MULT) begin
      sa = $signed(a);
      sb = $signed(b);
      p  = sa * sb;
      {ehi, elo} = p;
    end else if (op == OP_MULTU) begin
      up = {32'b0, a} * {32'b0, b};
      {ehi, elo} = up;
    end else if (b == 0) begin
      ehi = a;
      elo = 32'hFFFFFFFF;
      edz = 1'b1;
    end else if (op == OP_DIV) begin
      sa  = $signed(a);
      sb  = $signed(b);
      elo = 32'(sa / sb);
      ehi = 32'(sa % sb);
    end else begin
      elo = a / b;
      ehi = a % b;
    end
  endfunction

  // Issues a MULT/DIV and returns in the cycle where done should be visible.
  task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] ohi, output logic [31:0] olo,
                        output logic odz, output int bad);
    start = 1'b1; operation = op; operand1 = a; operand0 = b;
    @(posedge clk); #1;
    start = 1'b0; operation = 6'h00;
    lat = 0;
    bad = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat < 33 && busy !== 1'b1) bad++;
    end while (done !== 1'b1 && lat < 100);
    if (busy !== 1'b0) bad++;
    ohi = hi;
    olo = lo;
    odz = div_by_zero;
  endtask

  task automatic mt(input logic [5:0] op, input logic [31:0] v);
    start = 1'b1; operation = op; operand1 = v; operand0 = '0;
    @(posedge clk); #1;
    start = 1'b0; operation = 6'h00;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; operation = 6'h00; operand1 = '0; operand0 = '0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if ({hi, lo, result} !== 96'h0) $display("FAIL reset_hilo_result: got %h want 0", {hi, lo, result}); else pass_cnt++;
    total_cnt++; if ({write_enable, busy, done, div_by_zero} !== 4'b0) $display("FAIL reset_flags: got %b want 0000", {write_enable, busy, done, div_by_zero}); else pass_cnt++;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_plan_vectors();
    int lat, bad;
    logic [31:0] ohi, olo;
    logic odz;
    vecs[0] = '{OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[2] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[3] = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vecs[4] = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[5] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[6] = '{OP_DIV,   32'h00001234, 32'h0,        32'h00001234, 32'hFFFFFFFF, 1'b1};
    vecs[7] = '{OP_DIVU,  32'h8000DEAD, 32'h0,        32'h8000DEAD, 32'hFFFFFFFF, 1'b1};
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, ohi, olo, odz, bad);
      total_cnt++; if (lat !== 33) $display("FAIL plan%0d_latency: got %0d want 33", i, lat); else pass_cnt++;
      total_cnt++; if (ohi !== vecs[i].ehi) $display("FAIL plan%0d_hi: got %h want %h", i, ohi, vecs[i].ehi); else pass_cnt++;
      total_cnt++; if (olo !== vecs[i].elo) $display("FAIL plan%0d_lo: got %h want %h", i, olo, vecs[i].elo); else pass_cnt++;
      total_cnt++; if (odz !== vecs[i].edz) $display("FAIL plan%0d_dbz: got %b want %b", i, odz, vecs[i].edz); else pass_cnt++;
      total_cnt++; if (bad !== 0) $display("FAIL plan%0d_busy: got %0d bad cycles want 0", i, bad); else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++; if ({done, div_by_zero} !== 2'b00) $display("FAIL plan%0d_done_pulse: got %b want 00", i, {done, div_by_zero}); else pass_cnt++;
    end
  endtask

  task automatic test_random();
    int lat, bad;
    logic [31:0] ohi, olo, ehi, elo, a, b;
    logic odz, edz;
    logic [5:0] op;
    logic [31:0] specials [5];
    specials[0] = 32'h0; specials[1] = 32'h1; specials[2] = 32'hFFFFFFFF;
    specials[3] = 32'h80000000; specials[4] = 32'h7FFFFFFF;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(3))
        0: op = OP_MULT;
        1: op = OP_MULTU;
        2: op = OP_DIV;
        default: op = OP_DIVU;
      endcase
      a = ($urandom_range(4) == 0) ? specials[$urandom_range(4)] : $urandom;
      case ($urandom_range(5))
        0: b = specials[$urandom_range(4)];
        1: b = $urandom_range(255);
        default: b = $urandom;
      endcase
      model(op, a, b, ehi, elo, edz);
      run_op(op, a, b, lat, ohi, olo, odz, bad);
      total_cnt++;
      if (lat !== 33 || bad !== 0 || ohi !== ehi || olo !== elo || odz !== edz)
        $display("FAIL rand%0d op=%h a=%h b=%h: got lat=%0d bad=%0d hi=%h lo=%h dz=%b want lat=33 bad=0 hi=%h lo=%h dz=%b",
                 i, op, a, b, lat, bad, ohi, olo, odz, ehi, elo, edz);
      else pass_cnt++;
    end
  endtask

  task automatic test_mthi_mfhi();
    mt(OP_MTHI, 32'hCAFEBABE);
    total_cnt++; if (write_enable !== 1'b0) $display("FAIL mthi_no_we: got %b want 0", write_enable); else pass_cnt++;
    total_cnt++; if (hi !== 32'hCAFEBABE) $display("FAIL mthi_hi: got %h want cafebabe", hi); else pass_cnt++;
    mt(OP_MTLO, 32'h0BADF00D);
    total_cnt++; if (lo !== 32'h0BADF00D) $display("FAIL mtlo_lo: got %h want 0badf00d", lo); else pass_cnt++;
    mt(OP_MFHI, 32'h0);
    total_cnt++; if ({write_enable, result} !== {1'b1, 32'hCAFEBABE}) $display("FAIL mfhi: got we=%b res=%h want we=1 res=cafebabe", write_enable, result); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (write_enable !== 1'b0) $display("FAIL mfhi_we_pulse: got %b want 0", write_enable); else pass_cnt++;
    mt(OP_MFLO, 32'h0);
    total_cnt++; if ({write_enable, result} !== {1'b1, 32'h0BADF00D}) $display("FAIL mflo: got we=%b res=%h want we=1 res=0badf00d", write_enable, result); else pass_cnt++;
  endtask

  task automatic test_busy_ignore();
    int we_bad, lo_bad;
    logic [31:0] ehi, elo;
    logic edz;
    mt(OP_MTLO, 32'h5A5A5A5A);
    model(OP_MULTU, 32'h00012345, 32'h00067890, ehi, elo, edz);
    start = 1'b1; operation = OP_MULTU; operand1 = 32'h00012345; operand0 = 32'h00067890;
    @(posedge clk); #1;
    operation = OP_MFLO;
    we_bad = 0;
    lo_bad = 0;
    for (int n = 1; n <= 33; n++) begin
      @(posedge clk); #1;
      if (write_enable !== 1'b0) we_bad++;
      if (n <= 32 && lo !== 32'h5A5A5A5A) lo_bad++;
    end
    total_cnt++; if (we_bad !== 0) $display("FAIL busy_ignore_we: got %0d pulses want 0", we_bad); else pass_cnt++;
    total_cnt++; if (lo_bad !== 0) $display("FAIL busy_lo_stable: got %0d changed cycles want 0", lo_bad); else pass_cnt++;
    total_cnt++; if (done !== 1'b1) $display("FAIL busy_ignore_done: got %b want 1", done); else pass_cnt++;
    @(posedge clk); #1;
    start = 1'b0; operation = 6'h00;
    total_cnt++; if ({write_enable, result} !== {1'b1, elo}) $display("FAIL held_mflo: got we=%b res=%h want we=1 res=%h", write_enable, result, elo); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int lat, bad;
    logic [31:0] ohi, olo, ehi, elo;
    logic odz, edz;
    run_op(OP_MULT, 32'd6, 32'hFFFFFFF9, lat, ohi, olo, odz, bad);
    total_cnt++; if ({ohi, olo} !== 64'hFFFFFFFF_FFFFFFD6) $display("FAIL b2b_first: got %h want ffffffffffffffd6", {ohi, olo}); else pass_cnt++;
    model(OP_DIVU, 32'd1000, 32'd9, ehi, elo, edz);
    run_op(OP_DIVU, 32'd1000, 32'd9, lat, ohi, olo, odz, bad);
    total_cnt++; if (lat !== 33 || bad !== 0) $display("FAIL b2b_latency: got lat=%0d bad=%0d want 33/0", lat, bad); else pass_cnt++;
    total_cnt++; if ({ohi, olo, odz} !== {ehi, elo, edz}) $display("FAIL b2b_second: got %h %h %b want %h %h %b", ohi, olo, odz, ehi, elo, edz); else pass_cnt++;
    mt(OP_MFHI, 32'h0);
    total_cnt++; if ({write_enable, result} !== {1'b1, ehi}) $display("FAIL mfhi_in_done_cycle: got we=%b res=%h want we=1 res=%h", write_enable, result, ehi); else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    int done_seen;
    int lat, bad;
    logic [31:0] ohi, olo;
    logic odz;
    mt(OP_MTHI, 32'h11111111);
    mt(OP_MTLO, 32'h22222222);
    start = 1'b1; operation = OP_MULT; operand1 = 32'd123; operand0 = 32'd456;
    @(posedge clk); #1;
    start = 1'b0; operation = 6'h00;
    repeat (9) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if ({hi, lo} !== 64'h0) $display("FAIL abort_hilo: got %h want 0", {hi, lo}); else pass_cnt++;
    done_seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_seen++;
    end
    total_cnt++; if (done_seen !== 0) $display("FAIL abort_no_done: got %0d done pulses want 0", done_seen); else pass_cnt++;
    run_op(OP_MULTU, 32'd12, 32'd11, lat, ohi, olo, odz, bad);
    total_cnt++; if ({lat, ohi, olo} !== {32'd33, 32'd0, 32'd132}) $display("FAIL after_abort: got lat=%0d %h %h want 33 0 84", lat, ohi, olo); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_plan_vectors();
    test_random();
    test_mthi_mfhi();
    test_busy_ignore();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
